keccak_sponge_absorb: RTL and testbench
=======================================

Name: keccak_sponge_absorb

Overview:
Upstream feeder for the Keccak-f[1600] permutation core, which wraps the combinational round logic. It accepts a 64-bit little-endian lane stream, XORs each lane into the rate portion of a 1600-bit state register, and applies SHA-3/SHAKE multi-rate padding with a domain-separation byte. It launches the permutation at every full rate block and after the final padded block. It then presents the absorbed state to the squeeze stage.

Parameters:
RATE_WORDS, 17, rate in 64-bit lanes (17 = SHA3-256, 21 = SHAKE128, 9 = SHA3-512); legal range 1..24
DS_BYTE, 8'h06, domain-separation byte XORed at the first pad position (8'h1F for SHAKE)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_data  in  64  message lane, byte 0 = bits [7:0]
in_bytes  in  4  valid bytes in in_data when in_last=1 (0..8); must be 8 when in_last=0
in_last  in  1  final lane of the message
in_valid  in  1  lane valid
in_ready  out  1  lane accepted when in_valid & in_ready
perm_start  out  1  one-cycle pulse: permute perm_state
perm_state  out  1600  state to permute; lane i = bits [64i+:64]
perm_done  in  1  one-cycle pulse: perm_result valid
perm_result  in  1600  permuted state
out_valid  out  1  absorbed state valid
out_ready  in  1  consumer accepts the state
out_state  out  1600  final absorbed state (equals perm_state register)

Behaviour:
- One clock (clk); reset (rst) is synchronous and active-high.
- Reset: state register = 0, lane counter = 0, FSM = ABSORB, in_ready = 1, perm_start = 0, out_valid = 0.
- FSM states: ABSORB, PERM, PAD, PERM_LAST, DONE.
- ABSORB:
  - in_ready = 1.
  - On an accepted non-last lane: lane[cnt] ^= in_data, then cnt++.
  - If cnt was RATE_WORDS-1, set cnt = 0, pulse perm_start the next cycle, and go to PERM.
- Last lane accepted with in_bytes = b, at cnt = c:
  - lane[c] ^= in_data masked to the low b bytes.
  - Padding byte position is p = 8c + b.
  - If p < 8·RATE_WORDS: byte p ^= DS_BYTE; byte 8·RATE_WORDS-1 ^= 8'h80. Both XORs accumulate when they land on the same byte (e.g. 8'h86). Go to PERM_LAST with perm_start pulsed.
  - If p = 8·RATE_WORDS (c = RATE_WORDS-1, b = 8): go to PERM, then PAD.
- PERM and PERM_LAST:
  - in_ready = 0.
  - On perm_done, state ← perm_result.
  - From PERM, go to ABSORB, or to PAD if a pad is pending.
  - From PERM_LAST, go to DONE.
  - A perm_done arriving outside PERM or PERM_LAST is ignored.
- PAD: byte 0 ^= DS_BYTE; byte 8·RATE_WORDS-1 ^= 8'h80; pulse perm_start; go to PERM_LAST. Takes 1 cycle.
- DONE:
  - out_valid = 1, held with out_state stable until out_ready.
  - On handshake: state cleared to 0, cnt = 0, go to ABSORB. in_ready returns to 1 the following cycle.
- Capacity lanes (index ≥ RATE_WORDS) are never written by input or padding.
- perm_start is registered and asserts exactly 1 cycle after the triggering accept or PAD cycle.
- rst asserted in any state aborts the operation with the reset values above; a perm_done pending from the aborted operation is ignored.
- Latency: last-lane accept → perm_start is 1 cycle; perm_done → out_valid is 1 cycle.

Optional Feature:
KECCAK_SPONGE_MSGLEN_EN
- Defined:
  - Adds output msg_len [63:0]: count of message bytes accepted, incremented by 8 per non-last lane and by in_bytes on the last lane.
  - Valid while out_valid; cleared on reset and on the out handshake.
  - Wraps modulo 2^64.
- Undefined: the port and counter are absent.

Test Plan:
- Bench stub for all scenarios: identity permutation answering perm_done 3 cycles after perm_start.
- Empty message, RATE_WORDS=17: single lane, in_last=1, in_bytes=0 -> one perm_start; lane0 = 64'h06; lane16 = 64'h8000000000000000; all other lanes 0; out_valid after perm_done.
- "abc" (in_data=64'h636261, in_bytes=3) -> lane0 = 64'h06636261; lane16 bit 63 set.
- RATE_WORDS=1, single last lane with in_bytes=7, in_data all 8'hFF in the low 7 bytes -> byte 7 = 8'h86; exactly one perm_start.
- 17 full lanes, last flagged with in_bytes=8 -> two perm_start pulses; in_ready=0 between them; the second block has lane0 ^= 64'h06 and lane16 ^= 64'h8000000000000000.
- Hold out_ready=0 for 10 cycles -> out_state stable, in_ready=0; then out_ready=1 -> state 0, in_ready=1 on the next cycle.
- Assert rst 1 cycle while in PERM, then drive a late perm_done -> reset values; state stays 0; no out_valid.

Source files
------------

// File: rtl/keccak_sponge_absorb_if.sv
// Lane stream, permutation handshake and squeeze handoff for keccak_sponge_absorb.
// msg_len exists only when KECCAK_SPONGE_MSGLEN_EN is defined.
interface keccak_sponge_absorb_if;
    logic [63:0]   in_data;
    logic [3:0]    in_bytes;
    logic          in_last;
    logic          in_valid;
    logic          in_ready;
    logic          perm_start;
    logic [1599:0] perm_state;
    logic          perm_done;
    logic [1599:0] perm_result;
    logic          out_valid;
    logic          out_ready;
    logic [1599:0] out_state;
`ifdef KECCAK_SPONGE_MSGLEN_EN
    logic [63:0]   msg_len;

    modport master (
        output in_data, in_bytes, in_last, in_valid, perm_done, perm_result, out_ready,
        input  in_ready, perm_start, perm_state, out_valid, out_state, msg_len
    );
    modport slave (
        input  in_data, in_bytes, in_last, in_valid, perm_done, perm_result, out_ready,
        output in_ready, perm_start, perm_state, out_valid, out_state, msg_len
    );
`else
    modport master (
        output in_data, in_bytes, in_last, in_valid, perm_done, perm_result, out_ready,
        input  in_ready, perm_start, perm_state, out_valid, out_state
    );
    modport slave (
        input  in_data, in_bytes, in_last, in_valid, perm_done, perm_result, out_ready,
        output in_ready, perm_start, perm_state, out_valid, out_state
    );
`endif
endinterface

// File: rtl/keccak_sponge_absorb.sv
// Keccak sponge absorb stage: XORs 64-bit lanes into the rate, applies SHA-3 pad10*1 with
// DS_BYTE and drives the permutation core. Optional msg_len output: KECCAK_SPONGE_MSGLEN_EN.
module keccak_sponge_absorb #(
    parameter int unsigned RATE_WORDS = 17,
    parameter logic [7:0]  DS_BYTE    = 8'h06
) (
    input  logic                 clk,
    input  logic                 rst,
    keccak_sponge_absorb_if.slave bus
);
    localparam logic [4:0]  LastLane  = 5'(RATE_WORDS - 1);
    localparam int unsigned LastByte  = 8 * RATE_WORDS - 1;
    localparam logic [7:0]  RateBytes = 8'(8 * RATE_WORDS);

    typedef enum logic [2:0] {StAbsorb, StPerm, StPad, StPermLast, StDone} state_e;

    state_e        r_fsm;
    logic [1599:0] r_state;
    logic [4:0]    r_cnt;
    logic          r_pad_pend;
    logic          r_perm_start;

    logic          w_accept;
    logic [63:0]   w_mask;
    logic [7:0]    w_pad_pos;
    logic          w_pad_in_rate;
    logic [1599:0] w_absorbed;

    assign w_accept = bus.in_valid && (r_fsm == StAbsorb);

    // Lane XOR plus in-block padding when the pad position still fits in this block.
    always_comb begin
        w_mask        = bus.in_last ? ((64'd1 << {bus.in_bytes, 3'b000}) - 64'd1) : '1;
        w_pad_pos     = {r_cnt, 3'b000} + 8'(bus.in_bytes);
        w_pad_in_rate = bus.in_last && (w_pad_pos < RateBytes);
        w_absorbed    = r_state;
        w_absorbed[{r_cnt, 6'b000000} +: 64] =
            r_state[{r_cnt, 6'b000000} +: 64] ^ (bus.in_data & w_mask);
        if (w_pad_in_rate) begin
            w_absorbed[{w_pad_pos, 3'b000} +: 8] = w_absorbed[{w_pad_pos, 3'b000} +: 8] ^ DS_BYTE;
            w_absorbed[LastByte * 8 +: 8]        = w_absorbed[LastByte * 8 +: 8] ^ 8'h80;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm        <= StAbsorb;
            r_state      <= '0;
            r_cnt        <= '0;
            r_pad_pend   <= 1'b0;
            r_perm_start <= 1'b0;
        end else begin
            r_perm_start <= 1'b0;
            unique case (r_fsm)
                StAbsorb: begin
                    if (w_accept) begin
                        r_state <= w_absorbed;
                        if (bus.in_last) begin
                            r_cnt        <= '0;
                            r_perm_start <= 1'b1;
                            r_pad_pend   <= !w_pad_in_rate;
                            r_fsm        <= w_pad_in_rate ? StPermLast : StPerm;
                        end else if (r_cnt == LastLane) begin
                            r_cnt        <= '0;
                            r_perm_start <= 1'b1;
                            r_fsm        <= StPerm;
                        end else begin
                            r_cnt <= r_cnt + 5'd1;
                        end
                    end
                end
                StPerm: begin
                    if (bus.perm_done) begin
                        r_state <= bus.perm_result;
                        r_fsm   <= r_pad_pend ? StPad : StAbsorb;
                    end
                end
                // Message ended exactly on a block boundary: padding gets a block of its own.
                StPad: begin
                    r_state[7:0]                <= r_state[7:0] ^ DS_BYTE;
                    r_state[LastByte * 8 +: 8]  <= r_state[LastByte * 8 +: 8] ^ 8'h80;
                    r_pad_pend                  <= 1'b0;
                    r_perm_start                <= 1'b1;
                    r_fsm                       <= StPermLast;
                end
                StPermLast: begin
                    if (bus.perm_done) begin
                        r_state <= bus.perm_result;
                        r_fsm   <= StDone;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        r_state <= '0;
                        r_cnt   <= '0;
                        r_fsm   <= StAbsorb;
                    end
                end
                default: r_fsm <= StAbsorb;
            endcase
        end
    end

    assign bus.in_ready   = (r_fsm == StAbsorb);
    assign bus.perm_start = r_perm_start;
    assign bus.perm_state = r_state;
    assign bus.out_valid  = (r_fsm == StDone);
    assign bus.out_state  = r_state;

`ifdef KECCAK_SPONGE_MSGLEN_EN
    logic [63:0] r_msg_len;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_msg_len <= '0;
        end else if ((r_fsm == StDone) && bus.out_ready) begin
            r_msg_len <= '0;
        end else if (w_accept) begin
            r_msg_len <= r_msg_len + (bus.in_last ? 64'(bus.in_bytes) : 64'd8);
        end
    end

    assign bus.msg_len = r_msg_len;
`endif
endmodule

// File: tb/tb_keccak_sponge_absorb.sv
// Bench for keccak_sponge_absorb: two instances (rate 17 and rate 1) driven with directed and
// random messages; an identity permutation stub; byte-level pad10*1 reference model.
module tb_keccak_sponge_absorb;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst         [2];
    logic [63:0]   in_data     [2];
    logic [3:0]    in_bytes    [2];
    logic          in_last     [2];
    logic          in_valid    [2];
    logic          out_ready   [2];
    logic          perm_done   [2] = '{1'b0, 1'b0};
    logic [1599:0] perm_result [2] = '{'0, '0};
    logic          in_ready    [2];
    logic          perm_start  [2];
    logic          out_valid   [2];
    logic [1599:0] perm_state  [2];
    logic [1599:0] out_state   [2];

    keccak_sponge_absorb_if bus0 ();
    keccak_sponge_absorb_if bus1 ();

    assign bus0.in_data     = in_data[0];
    assign bus0.in_bytes    = in_bytes[0];
    assign bus0.in_last     = in_last[0];
    assign bus0.in_valid    = in_valid[0];
    assign bus0.out_ready   = out_ready[0];
    assign bus0.perm_done   = perm_done[0];
    assign bus0.perm_result = perm_result[0];
    assign in_ready[0]      = bus0.in_ready;
    assign perm_start[0]    = bus0.perm_start;
    assign perm_state[0]    = bus0.perm_state;
    assign out_valid[0]     = bus0.out_valid;
    assign out_state[0]     = bus0.out_state;

    assign bus1.in_data     = in_data[1];
    assign bus1.in_bytes    = in_bytes[1];
    assign bus1.in_last     = in_last[1];
    assign bus1.in_valid    = in_valid[1];
    assign bus1.out_ready   = out_ready[1];
    assign bus1.perm_done   = perm_done[1];
    assign bus1.perm_result = perm_result[1];
    assign in_ready[1]      = bus1.in_ready;
    assign perm_start[1]    = bus1.perm_start;
    assign perm_state[1]    = bus1.perm_state;
    assign out_valid[1]     = bus1.out_valid;
    assign out_state[1]     = bus1.out_state;

`ifdef KECCAK_SPONGE_MSGLEN_EN
    logic [63:0] msg_len [2];
    assign msg_len[0] = bus0.msg_len;
    assign msg_len[1] = bus1.msg_len;
`endif

    keccak_sponge_absorb #(.RATE_WORDS(17), .DS_BYTE(8'h06)) dut0 (
        .clk (clk),
        .rst (rst[0]),
        .bus (bus0)
    );
    keccak_sponge_absorb #(.RATE_WORDS(1), .DS_BYTE(8'h06)) dut1 (
        .clk (clk),
        .rst (rst[1]),
        .bus (bus1)
    );

    int n_cmp = 0;
    int n_err = 0;

    function automatic int rw(input int d);
        return (d == 0) ? 17 : 1;
    endfunction

    function automatic void chk(input bit ok, input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endfunction

    function automatic void chk_st(input string name, input logic [1599:0] act,
                                   input logic [1599:0] exp);
        int l = 0;
        for (int i = 24; i >= 0; i--) if (act[64*i +: 64] !== exp[64*i +: 64]) l = i;
        chk(act === exp, $sformatf("%s lane%0d", name, l), act[64*l +: 64], exp[64*l +: 64]);
    endfunction

    // Reference: message bytes padded with pad10*1 + DS, XORed block by block (identity perm).
    logic [7:0]    msg_b   [0:511];
    logic [1599:0] exp_blk [2][8];
    int            exp_n   [2] = '{0, 0};
    int            exp_i   [2] = '{0, 0};
    int            n_start [2] = '{0, 0};
    int            cd      [2] = '{0, 0};
    logic          busy    [2] = '{1'b0, 1'b0};
    logic [1599:0] cap     [2];
    logic [1599:0] last_out[2];
    logic [63:0]   exp_len [2];

    task automatic build_expect(input int d, input int len);
        int rb;
        int nblk;
        int pos;
        logic [7:0] st [200];
        logic [7:0] b;
        rb   = 8 * rw(d);
        nblk = len / rb + 1;
        for (int i = 0; i < 200; i++) st[i] = 8'h00;
        for (int k = 0; k < nblk; k++) begin
            for (int j = 0; j < rb; j++) begin
                pos = k * rb + j;
                b = (pos < len) ? msg_b[pos] : 8'h00;
                if (pos == len) b = b ^ 8'h06;
                if (k == nblk - 1 && j == rb - 1) b = b ^ 8'h80;
                st[j] = st[j] ^ b;
            end
            for (int i = 0; i < 200; i++) exp_blk[d][k][8*i +: 8] = st[i];
        end
        exp_n[d]   = nblk;
        exp_i[d]   = 0;
        n_start[d] = 0;
        exp_len[d] = 64'(len);
    endtask

    // Per-cycle checker plus identity permutation stub (perm_done 3 cycles after perm_start).
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst[d]) begin
                exp_n[d] = 0;
                exp_i[d] = 0;
                busy[d]  = 1'b0;
            end else begin
                if (perm_start[d]) begin
                    n_start[d]++;
                    chk(exp_i[d] < exp_n[d], "perm_start_expected", 64'(exp_i[d]), 64'(exp_n[d]));
                    if (exp_i[d] < exp_n[d]) begin
                        chk_st("perm_state", perm_state[d], exp_blk[d][exp_i[d]]);
                        exp_i[d]++;
                    end
                    busy[d] = 1'b1;
                end else if (busy[d]) begin
                    chk(in_ready[d] === 1'b0, "in_ready_during_perm", 64'(in_ready[d]), 64'd0);
                end
                if (out_valid[d]) begin
                    chk(exp_n[d] > 0 && exp_i[d] == exp_n[d], "out_after_all_blocks",
                        64'(exp_i[d]), 64'(exp_n[d]));
                    if (exp_n[d] > 0) chk_st("out_state", out_state[d], exp_blk[d][exp_n[d]-1]);
                    chk(in_ready[d] === 1'b0, "in_ready_while_out_valid", 64'(in_ready[d]), 64'd0);
`ifdef KECCAK_SPONGE_MSGLEN_EN
                    chk(msg_len[d] === exp_len[d], "msg_len", msg_len[d], exp_len[d]);
`endif
                end
            end
            perm_done[d] = 1'b0;
            if (cd[d] > 0) begin
                cd[d]--;
                if (cd[d] == 0) begin
                    perm_done[d]   = 1'b1;
                    perm_result[d] = cap[d];
                    busy[d]        = 1'b0;
                end
            end
            if (perm_start[d]) begin
                cd[d]  = 2;
                cap[d] = perm_state[d];
            end
        end
    end

    task automatic put_lane(input int d, input logic [63:0] data, input logic [3:0] nb,
                            input logic last);
        int n;
        n = 0;
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        in_data[d]  = data;
        in_bytes[d] = nb;
        in_last[d]  = last;
        in_valid[d] = 1'b1;
        while (!in_ready[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(in_ready[d] === 1'b1, "lane_accept", 64'(in_ready[d]), 64'd1);
        @(negedge clk);
        in_valid[d] = 1'b0;
        in_data[d]  = {$urandom, $urandom};
    endtask

    task automatic send_msg(input int d, input int len, input bit split);
        int nl;
        int nb;
        logic [63:0] w;
        nl = (len + 7) / 8;
        if (nl == 0) nl = 1;
        nb = 0;
        for (int l = 0; l < nl; l++) begin
            nb = (len - 8 * l > 8) ? 8 : len - 8 * l;
            w  = {$urandom, $urandom};
            for (int i = 0; i < nb; i++) w[8*i +: 8] = msg_b[8*l + i];
            put_lane(d, w, 4'(nb), (l == nl - 1) && !(split && nb == 8));
        end
        if (split && nb == 8) put_lane(d, {$urandom, $urandom}, 4'd0, 1'b1);
    endtask

    task automatic run_msg(input int d, input int len, input bit split, input int hold);
        int n;
        n = 0;
        build_expect(d, len);
        send_msg(d, len, split);
        while (!out_valid[d] && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(out_valid[d] === 1'b1, "out_valid_arrives", 64'(out_valid[d]), 64'd1);
        last_out[d] = out_state[d];
        repeat (hold) @(negedge clk);
        chk(out_valid[d] === 1'b1, "out_valid_held", 64'(out_valid[d]), 64'd1);
        out_ready[d] = 1'b1;
        @(negedge clk);
        out_ready[d] = 1'b0;
        chk(in_ready[d] === 1'b1, "in_ready_after_done", 64'(in_ready[d]), 64'd1);
        chk(out_valid[d] === 1'b0, "out_valid_drops", 64'(out_valid[d]), 64'd0);
        chk_st("state_cleared", perm_state[d], '0);
        chk(n_start[d] == exp_n[d], "perm_start_count", 64'(n_start[d]), 64'(exp_n[d]));
    endtask

    initial begin
        logic [63:0] lane0;
        for (int d = 0; d < 2; d++) begin
            rst[d]       = 1'b1;
            in_data[d]   = '0;
            in_bytes[d]  = '0;
            in_last[d]   = 1'b0;
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk(in_ready[d] === 1'b1, "reset_in_ready", 64'(in_ready[d]), 64'd1);
            chk(perm_start[d] === 1'b0, "reset_perm_start", 64'(perm_start[d]), 64'd0);
            chk(out_valid[d] === 1'b0, "reset_out_valid", 64'(out_valid[d]), 64'd0);
            chk_st("reset_state", perm_state[d], '0);
        end
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);

        // Empty message.
        run_msg(0, 0, 1'b0, 2);
        chk(last_out[0][63:0] === 64'h06, "empty_lane0", last_out[0][63:0], 64'h06);
        chk(last_out[0][1087:1024] === 64'h8000000000000000, "empty_lane16",
            last_out[0][1087:1024], 64'h8000000000000000);

        // "abc", then again with out_ready held low for 10 cycles.
        msg_b[0] = 8'h61;
        msg_b[1] = 8'h62;
        msg_b[2] = 8'h63;
        run_msg(0, 3, 1'b0, 1);
        chk(last_out[0][63:0] === 64'h06636261, "abc_lane0", last_out[0][63:0], 64'h06636261);
        chk(64'(last_out[0][1087]) == 64'd1, "abc_lane16_bit63", 64'(last_out[0][1087]), 64'd1);
        run_msg(0, 3, 1'b0, 10);

        // Rate 1, seven 0xFF bytes: DS and final bit share byte 7.
        for (int i = 0; i < 7; i++) msg_b[i] = 8'hFF;
        run_msg(1, 7, 1'b0, 0);
        chk(last_out[1][63:0] === 64'h86FFFFFFFFFFFFFF, "rate1_byte7", last_out[1][63:0],
            64'h86FFFFFFFFFFFFFF);
        chk(n_start[1] == 1, "rate1_one_perm", 64'(n_start[1]), 64'd1);

        // Exactly one full block, flagged last on lane 16, then via a trailing empty lane.
        for (int i = 0; i < 136; i++) msg_b[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) lane0[8*i +: 8] = msg_b[i];
        run_msg(0, 136, 1'b0, 0);
        chk(n_start[0] == 2, "full_block_two_perms", 64'(n_start[0]), 64'd2);
        chk(last_out[0][63:0] === (lane0 ^ 64'h06), "pad_block_lane0", last_out[0][63:0],
            lane0 ^ 64'h06);
        run_msg(0, 136, 1'b1, 0);
        chk(n_start[0] == 2, "split_block_two_perms", 64'(n_start[0]), 64'd2);

        // Reset while a permutation is outstanding; its perm_done arrives afterwards.
        for (int i = 0; i < 200; i++) msg_b[i] = 8'($urandom);
        build_expect(0, 200);
        for (int l = 0; l < 17; l++) begin
            for (int i = 0; i < 8; i++) lane0[8*i +: 8] = msg_b[8*l + i];
            put_lane(0, lane0, 4'd8, 1'b0);
        end
        #1 rst[0] = 1'b1;
        @(negedge clk);
        #1 rst[0] = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk(in_ready[0] === 1'b1, "abort_in_ready", 64'(in_ready[0]), 64'd1);
            chk(out_valid[0] === 1'b0, "abort_out_valid", 64'(out_valid[0]), 64'd0);
            chk_st("abort_state", perm_state[0], '0);
        end

        // Random messages on both rates.
        for (int t = 0; t < 30; t++) begin
            int d;
            int len;
            d   = int'($urandom_range(0, 1));
            len = (d == 0) ? int'($urandom_range(0, 300)) : int'($urandom_range(0, 40));
            for (int i = 0; i < len; i++) msg_b[i] = 8'($urandom);
            run_msg(d, len, 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
